// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one pulse-request memory port between two requesters
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_request_enable,
  input  logic        m0_mode,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_response_enable,
  output logic [31:0] m0_data,
  input  logic        m1_request_enable,
  input  logic        m1_mode,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_response_enable,
  output logic [31:0] m1_data,
  output logic        mem_request_enable,
  output logic        mem_mode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_response_enable,
  input  logic [31:0] mem_data,
  output logic        err_timeout,
  output logic        err_overflow
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [1:0] req, v, clr, rq_mode, s_mode;
  logic [1:0][31:0] rq_addr, rq_wdata, s_addr, s_wdata;
  logic [1:0][3:0] rq_wstrb, s_wstrb;
  logic [31:0] cnt;
  logic last_grant, owner, gnt, issue, finish, tmo, done;
  assign req = {m1_request_enable, m0_request_enable};
  assign rq_mode = {m1_mode, m0_mode};
  assign rq_addr = {m1_addr, m0_addr};
  assign rq_wdata = {m1_wdata, m0_wdata};
  assign rq_wstrb = {m1_wstrb, m0_wstrb};
  assign done = finish | tmo;
  assign clr = {done & owner, done & ~owner};
  // Next-state and grant decision; a tie goes to the port not granted last
  always_comb begin
    state_n = state;
    issue = 1'b0;
    finish = 1'b0;
    tmo = 1'b0;
    gnt = (v[0] && v[1]) ? ~last_grant : v[1];
    if (state == IDLE) begin
      issue = |v;
      state_n = issue ? WAIT : IDLE;
    end else begin
      finish = mem_response_enable;
      tmo = !mem_response_enable && TIMEOUT_CYCLES != 0 && cnt == TIMEOUT_CYCLES;
      state_n = (finish || tmo) ? IDLE : WAIT;
    end
  end
  // State register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // Pending slots load only when empty; a request in the clearing cycle sees the slot full
  always_ff @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (rst) v[k] <= 1'b0;
      else if (clr[k]) v[k] <= 1'b0;
      else if (req[k] && !v[k]) begin
        v[k] <= 1'b1;
        s_mode[k] <= rq_mode[k];
        s_addr[k] <= rq_addr[k];
        s_wdata[k] <= rq_wdata[k];
        s_wstrb[k] <= rq_wstrb[k];
      end
  // Downstream issue, response routing, timeout counter and error pulses
  always_ff @(posedge clk)
    if (rst) begin
      mem_request_enable <= 1'b0;
      mem_mode <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      m0_response_enable <= 1'b0;
      m1_response_enable <= 1'b0;
      m0_data <= '0;
      m1_data <= '0;
      err_timeout <= 1'b0;
      err_overflow <= 1'b0;
      owner <= 1'b0;
      last_grant <= 1'b1;
      cnt <= '0;
    end else begin
      mem_request_enable <= issue;
      if (issue) begin
        mem_mode <= s_mode[gnt];
        mem_addr <= s_addr[gnt];
        mem_wdata <= s_wdata[gnt];
        mem_wstrb <= s_wstrb[gnt];
        owner <= gnt;
      end
      cnt <= issue ? '0 : (state == WAIT && TIMEOUT_CYCLES != 0) ? cnt + 32'd1 : cnt;
      m0_response_enable <= done && !owner;
      m1_response_enable <= done && owner;
      if (done && !owner) m0_data <= tmo ? '0 : mem_data;
      if (done && owner) m1_data <= tmo ? '0 : mem_data;
      last_grant <= finish ? owner : last_grant;
      err_timeout <= tmo;
      err_overflow <= |(req & v);
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic m0_request_enable = 0, m0_mode = 0, m1_request_enable = 0, m1_mode = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, mem_data = 0;
  logic [3:0] m0_wstrb = 0, m1_wstrb = 0;
  logic m0_response_enable, m1_response_enable, mem_request_enable, mem_mode;
  logic [31:0] m0_data, m1_data, mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic mem_response_enable = 0, err_timeout, err_overflow;
  int cyc = 0, n_cmp = 0, n_fail = 0, t;
  typedef struct {int cyc; logic [31:0] a; logic m; logic [31:0] w; logic [3:0] s;} mem_t;
  typedef struct {int cyc; logic [31:0] d;} ev_t;
  mem_t q_mem[$];
  ev_t q_ev[4][$];
  string ev_nm[4] = '{"m0_resp", "m1_resp", "err_timeout", "err_overflow"};

  mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_request_enable(m0_request_enable), .m0_mode(m0_mode), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_response_enable(m0_response_enable), .m0_data(m0_data),
    .m1_request_enable(m1_request_enable), .m1_mode(m1_mode), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_response_enable(m1_response_enable), .m1_data(m1_data),
    .mem_request_enable(mem_request_enable), .mem_mode(mem_mode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_response_enable(mem_response_enable),
    .mem_data(mem_data), .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: every output pulse must match the head of its expectation queue
  always @(negedge clk) begin
    logic [3:0] en;
    logic [31:0] d [4];
    mem_t em;
    ev_t ee;
    if (mem_request_enable) begin
      check("mem_req_expected", 32'(q_mem.size() != 0), 32'd1);
      if (q_mem.size() != 0) begin
        em = q_mem.pop_front();
        check("mem_req_cycle", 32'(cyc), 32'(em.cyc));
        check("mem_addr", mem_addr, em.a);
        check("mem_mode", 32'(mem_mode), 32'(em.m));
        check("mem_wdata", mem_wdata, em.w);
        check("mem_wstrb", 32'(mem_wstrb), 32'(em.s));
      end
    end
    en = {err_overflow, err_timeout, m1_response_enable, m0_response_enable};
    d = '{m0_data, m1_data, 32'h0, 32'h0};
    for (int k = 0; k < 4; k++)
      if (en[k]) begin
        check({ev_nm[k], "_expected"}, 32'(q_ev[k].size() != 0), 32'd1);
        if (q_ev[k].size() != 0) begin
          ee = q_ev[k].pop_front();
          check({ev_nm[k], "_cycle"}, 32'(cyc), 32'(ee.cyc));
          check({ev_nm[k], "_data"}, d[k], ee.d);
        end
      end
  end

  task automatic step();
    @(negedge clk);
    m0_request_enable = 0;
    m1_request_enable = 0;
    mem_response_enable = 0;
  endtask

  task automatic goto(int c);
    while (cyc < c) step();
  endtask

  task automatic drive(int p, logic md, logic [31:0] a, logic [31:0] w, logic [3:0] s);
    if (p == 0) begin
      m0_request_enable = 1; m0_mode = md; m0_addr = a; m0_wdata = w; m0_wstrb = s;
    end else begin
      m1_request_enable = 1; m1_mode = md; m1_addr = a; m1_wdata = w; m1_wstrb = s;
    end
  endtask

  task automatic respond(logic [31:0] d);
    mem_response_enable = 1;
    mem_data = d;
  endtask

  task automatic exp_mem(int c, logic [31:0] a, logic m, logic [31:0] w, logic [3:0] s);
    q_mem.push_back('{c, a, m, w, s});
  endtask

  task automatic exp_ev(int k, int c, logic [31:0] d);
    q_ev[k].push_back('{c, d});
  endtask

  task automatic check_zero(string tag);
    check({tag, "_pulses"}, 32'({m0_response_enable, m1_response_enable, mem_request_enable, err_timeout, err_overflow}), 32'h0);
    check({tag, "_m0_data"}, m0_data, 32'h0);
    check({tag, "_m1_data"}, m1_data, 32'h0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_mem_mode_wstrb"}, 32'({mem_mode, mem_wstrb}), 32'h0);
  endtask

  initial begin
    step(); step(); step();
    check_zero("reset");
    rst = 0;
    step();
    // Contention after reset: order 0,1,0,1
    t = cyc;
    drive(0, 0, 32'h10, 0, 0); drive(1, 0, 32'h20, 0, 0);
    exp_mem(t + 2, 32'h10, 0, 0, 0); exp_ev(0, t + 4, 32'hA0);
    exp_mem(t + 5, 32'h20, 0, 0, 0); exp_ev(1, t + 7, 32'hA1);
    goto(t + 3); respond(32'hA0);
    goto(t + 6); respond(32'hA1);
    goto(t + 8);
    drive(0, 0, 32'h10, 0, 0); drive(1, 0, 32'h20, 0, 0);
    exp_mem(t + 10, 32'h10, 0, 0, 0); exp_ev(0, t + 12, 32'hB0);
    exp_mem(t + 13, 32'h20, 0, 0, 0); exp_ev(1, t + 15, 32'hB1);
    goto(t + 11); respond(32'hB0);
    goto(t + 14); respond(32'hB1);
    goto(t + 17);
    // Write on port 1
    t = cyc;
    drive(1, 1, 32'h2004, 32'h12345678, 4'b0011);
    exp_mem(t + 2, 32'h2004, 1, 32'h12345678, 4'b0011); exp_ev(1, t + 4, 32'hCAFEF00D);
    goto(t + 3); respond(32'hCAFEF00D);
    goto(t + 6);
    // Single read on port 0
    t = cyc;
    drive(0, 0, 32'h1000, 0, 0);
    exp_mem(t + 2, 32'h1000, 0, 0, 0); exp_ev(0, t + 5, 32'hDEADBEEF);
    goto(t + 4); respond(32'hDEADBEEF);
    goto(t + 7);
    // Overflow: second pulse while pending, third pulse in the clearing cycle
    t = cyc;
    drive(0, 0, 32'h3000, 0, 0);
    exp_mem(t + 2, 32'h3000, 0, 0, 0);
    goto(t + 2); drive(0, 0, 32'h3004, 0, 0); exp_ev(3, t + 3, 0);
    goto(t + 4); respond(32'h33); drive(0, 0, 32'h3008, 0, 0);
    exp_ev(0, t + 5, 32'h33); exp_ev(3, t + 5, 0);
    goto(t + 8);
    // Timeout with port 1 pending and stray responses in IDLE
    t = cyc;
    drive(0, 0, 32'h4000, 0, 0);
    exp_mem(t + 2, 32'h4000, 0, 0, 0);
    goto(t + 3); drive(1, 0, 32'h5000, 0, 0);
    exp_ev(0, t + 11, 0); exp_ev(2, t + 11, 0);
    exp_mem(t + 12, 32'h5000, 0, 0, 0); exp_ev(1, t + 15, 32'h55);
    goto(t + 11); respond(32'hBAD0BAD0);
    goto(t + 14); respond(32'h55);
    goto(t + 17); respond(32'hBAD1BAD1);
    goto(t + 20);
    // Reset mid-WAIT with port 1 pending
    t = cyc;
    drive(0, 0, 32'h6000, 0, 0);
    exp_mem(t + 2, 32'h6000, 0, 0, 0);
    goto(t + 2); drive(1, 0, 32'h7000, 0, 0);
    goto(t + 4); rst = 1;
    step();
    check_zero("midreset");
    rst = 0;
    goto(t + 6); respond(32'h66);
    goto(t + 8); drive(1, 0, 32'h7004, 0, 0);
    exp_mem(t + 10, 32'h7004, 0, 0, 0); exp_ev(1, t + 12, 32'h77);
    goto(t + 11); respond(32'h77);
    goto(t + 16);
    check("mem_req_outstanding", 32'(q_mem.size()), 32'd0);
    for (int k = 0; k < 4; k++) check({ev_nm[k], "_outstanding"}, 32'(q_ev[k].size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single pulse-request memory port (`mem_request_enable` / `mem_response_enable` bus) between the virtio DMA engine (port 0) and a second bus master (port 1, e.g. core-side loader). Each requester issues one-cycle request pulses and waits for a one-cycle response pulse. The arbiter latches requests, serialises them onto the downstream port with round-robin fairness, and routes each response back to its owner. One transaction is outstanding downstream at a time.

## Interface
- `TIMEOUT_CYCLES`, default 1024: max cycles in WAIT before a forced error response; 0 disables the timeout.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `m0_request_enable` in 1: port 0 request pulse.
- `m0_mode` in 1: 0 read, 1 write.
- `m0_addr` in 32, `m0_wdata` in 32, `m0_wstrb` in 4: request fields, sampled with the pulse.
- `m0_response_enable` out 1: port 0 response pulse.
- `m0_data` out 32: read data, valid with the pulse.
- `m1_*`: identical set for port 1.
- `mem_request_enable` out 1: downstream request pulse.
- `mem_mode` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_wstrb` out 4: downstream fields.
- `mem_response_enable` in 1: downstream response pulse.
- `mem_data` in 32: downstream read data.
- `err_timeout` out 1: one-cycle pulse when a timeout fires.
- `err_overflow` out 1: one-cycle pulse when a request is dropped.

## Operation
- Per-port pending slot: `valid` plus mode/addr/wdata/wstrb.
  - `mN_request_enable` with the slot empty loads the slot.
  - `mN_request_enable` with the slot full drops the request, leaves the slot unchanged, and pulses `err_overflow`.
- `last_grant` register (1 bit) records the port most recently granted.
- FSM states: IDLE, WAIT.
- IDLE:
  - No pending slot: stay in IDLE.
  - Exactly one pending slot: grant that port.
  - Both pending: grant the port that is not `last_grant`.
  - On grant: register `mem_*` fields from the granted slot, set `mem_request_enable`=1, set `owner`, clear the timeout counter, go to WAIT.
- WAIT:
  - `mem_request_enable`=0 from the second WAIT cycle on. Downstream fields hold their last values.
  - `mem_response_enable`=1 (accepted on any WAIT cycle, including the first):
    - register `m<owner>_data`=`mem_data` and `m<owner>_response_enable`=1;
    - clear the owner's slot, set `last_grant`=owner, go to IDLE.
  - Otherwise, if `TIMEOUT_CYCLES`≠0, increment the counter. When the counter reaches `TIMEOUT_CYCLES`:
    - respond to the owner with data 32'h0 and pulse `err_timeout`;
    - clear the owner's slot, go to IDLE.
- `mem_response_enable` in IDLE is ignored. This covers late responses after a timeout and responses outstanding at reset.
- Mode and write fields pass through unchanged. Write responses are returned exactly like read responses, with `mN_data`=`mem_data`.
- A request on the non-owner port during WAIT is latched normally and issued after the current transaction completes.

## Timing
- Reset (rst=1 at an edge):
  - all outputs 0;
  - both slots invalid, state IDLE, `last_grant`=1 (port 0 wins the first tie), counter 0.
  - Applies mid-transaction: the in-flight owner receives no response.
- Request pulse at cycle T (arbiter idle, no contention): slot valid at T+1, `mem_request_enable` high in T+2 only.
- Downstream response at cycle R: `mN_response_enable` high in R+1 only, with `mN_data` valid in the same cycle; state is IDLE in R+1.
- Earliest next downstream request: `mem_request_enable` in R+2.
- All `mN_response_enable`, `mem_request_enable` and error outputs are single-cycle pulses.
- Simultaneous arrival:
  - Request pulses on both ports in the same cycle are both latched.
  - A request pulse in the same cycle as its slot being cleared by a response or timeout counts as slot-full: dropped, with `err_overflow`.
- Timeout: counter reaching `TIMEOUT_CYCLES` means response pulse at WAIT entry + `TIMEOUT_CYCLES` + 1.

## Test plan
- Single read on port 0: `m0` read addr 0x1000 at T; downstream replies 0xDEADBEEF at T+4. Required:
  - `mem_request_enable` at T+2 with `mem_addr`=0x1000, `mem_mode`=0;
  - `m0_response_enable` at T+5 with `m0_data`=0xDEADBEEF;
  - no `m1` activity.
- Contention: both ports request in the same cycle after reset (A0=0x10, A1=0x20). Required: 0x10 issued first, then 0x20. Repeat both again; required order alternates 0x20 is not favoured twice (round-robin order 0,1,0,1).
- Write on port 1: wdata 0x12345678, wstrb 4'b0011, addr 0x2004. Required: downstream fields match exactly, `mem_mode`=1, and the response is routed only to `m1`.
- Overflow: port 0 pulses twice before its response. Required: `err_overflow` on the second pulse and exactly one downstream request with the first address.
- Timeout (`TIMEOUT_CYCLES`=8, downstream never replies). Required:
  - `m0_response_enable` with data 0 and `err_timeout` 9 cycles after WAIT entry;
  - a later stray `mem_response_enable` in IDLE produces no response pulse;
  - a pending port 1 request then issues.
- Reset mid-WAIT: assert `rst` for 1 cycle while port 0 is outstanding and port 1 is pending. Required:
  - all outputs 0 and both slots cleared;
  - a subsequent downstream response is ignored;
  - a new port 1 request issues at T+2.
